// File: rtl/nor_n_filtered.sv
// WIDTH-input NOR reduction built from NOR4 leaves, with an optional leaf
// register stage and a consecutive-enabled-cycle deglitch filter on the result.
module nor_n_filtered #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FILT      = 2,
  parameter int unsigned PIPE      = 1,
  parameter bit          RESET_VAL = 1'b1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  output logic             ZN,
  output logic             ZN_CHG
);

  localparam int unsigned G  = (WIDTH + 3) / 4;
  localparam int unsigned LW = 4 * G;
  localparam int unsigned CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  logic [LW-1:0] a_pad;
  logic [G-1:0]  leaf_c;
  logic [G-1:0]  leaf;
  logic          raw;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          zn_nxt;
  logic          chg_nxt;

  // Zero-extend A so the last group's missing bits read as 0.
  assign a_pad = LW'(A);

  always_comb begin
    leaf_c = '0;
    for (int k = 0; k < int'(G); k++) begin
      leaf_c[k] = ~|a_pad[4*k +: 4];
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic [G-1:0] leaf_q;

    // Leaf registers reset to the NOR of all-zero inputs.
    always_ff @(posedge CLK) begin
      if (!RN) begin
        leaf_q <= '1;
      end else if (EN) begin
        leaf_q <= leaf_c;
      end
    end

    assign leaf = leaf_q;
  end else begin : g_comb
    assign leaf = leaf_c;
  end

  assign raw = &leaf;

  // Filter: adopt raw only after it differs from ZN for FILT enabled cycles.
  always_comb begin
    cnt_nxt = cnt_q;
    zn_nxt  = ZN;
    chg_nxt = 1'b0;
    if (EN) begin
      if (raw == ZN) begin
        cnt_nxt = '0;
      end else if (cnt_q == CNT_LAST) begin
        zn_nxt  = raw;
        cnt_nxt = '0;
        chg_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      ZN     <= RESET_VAL;
      ZN_CHG <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ZN     <= zn_nxt;
      ZN_CHG <= chg_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

endmodule
